// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - samples an async 7-segment bus, waits for a stable pattern, decodes it to a digit stream
// Two-flop synchronizer, stability counter, decoder, optional repeat filter and one-entry output slot.

module seg7_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter int REPORT_REPEATS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] segments_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       blank,
  output logic       err_invalid,
  output logic       err_overflow,
  input  logic       err_clr
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  logic [6:0] s1, s2, cand;
  logic [3:0] cnt;
  logic       done;
  logic [2:0] last_digit;
  logic       last_vld;

  logic       stable_ev;
  logic [2:0] dec_digit;
  logic       dec_legal;
  logic       dec_blank;
  logic       is_repeat;
  logic       emit, load, drop;
  logic       blank_ev, inv_ev;

  assign stable_ev = en && (s2 == cand) && (cnt == CNT_LAST) && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      s1 <= segments_in;
      s2 <= s1;
      if (!en) begin
        cnt  <= '0;
        done <= 1'b0;
        cand <= s2;
      end else if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
        done <= 1'b0;
      end else begin
        if (cnt < CNT_LAST)
          cnt <= cnt + 4'd1;
        if (stable_ev)
          done <= 1'b1;
      end
    end
  end

  // At the stable event s2 == cand, so the candidate is the pattern to decode.
  always_comb begin
    dec_digit = '0;
    dec_legal = 1'b0;
    dec_blank = 1'b0;
    case (cand)
      7'b0111111: begin dec_digit = 3'd0; dec_legal = 1'b1; end
      7'b0000110: begin dec_digit = 3'd1; dec_legal = 1'b1; end
      7'b1011011: begin dec_digit = 3'd2; dec_legal = 1'b1; end
      7'b1001111: begin dec_digit = 3'd3; dec_legal = 1'b1; end
      7'b1100110: begin dec_digit = 3'd4; dec_legal = 1'b1; end
      7'b1101101: begin dec_digit = 3'd5; dec_legal = 1'b1; end
      7'b1111101: begin dec_digit = 3'd6; dec_legal = 1'b1; end
      7'b0000111: begin dec_digit = 3'd7; dec_legal = 1'b1; end
      7'b0000000: dec_blank = 1'b1;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign is_repeat = (REPORT_REPEATS == 0) && last_vld && (last_digit == dec_digit);
  assign emit      = stable_ev && dec_legal && !is_repeat;
  assign load      = emit && (!digit_valid || digit_ready);
  assign drop      = emit && digit_valid && !digit_ready;
  assign blank_ev  = stable_ev && dec_blank;
  assign inv_ev    = stable_ev && !dec_legal && !dec_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_out    <= '0;
      digit_valid  <= 1'b0;
      last_digit   <= '0;
      last_vld     <= 1'b0;
      blank        <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (load) begin
        digit_out   <= {1'b0, dec_digit};
        digit_valid <= 1'b1;
        last_digit  <= dec_digit;
        last_vld    <= 1'b1;
      end else if (digit_valid && digit_ready) begin
        digit_valid <= 1'b0;
      end

      // A blank or bad pattern in between lets the same digit be reported again.
      if (blank_ev || inv_ev)
        last_vld <= 1'b0;

      if (blank_ev)
        blank <= 1'b1;
      else if (inv_ev || (stable_ev && dec_legal))
        blank <= 1'b0;

      if (inv_ev)
        err_invalid <= 1'b1;
      else if (err_clr)
        err_invalid <= 1'b0;

      if (drop)
        err_overflow <= 1'b1;
      else if (err_clr)
        err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed, table-driven bench for seg7_reader
// Two instances share stimulus: repeats suppressed (dut) and repeats reported (dut_rep).

module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst, en, digit_ready, err_clr;
  logic [6:0] seg;
  logic [3:0] d0, d1;
  logic       v0, v1, b0, b1, ei0, ei1, eo0, eo1;

  int nvec = 0;
  int nbad = 0;
  int hs0 = 0, hs1 = 0, last0 = 0, last1 = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4), .REPORT_REPEATS(0)) dut (
    .clk(clk), .rst(rst), .en(en), .segments_in(seg),
    .digit_out(d0), .digit_valid(v0), .digit_ready(digit_ready),
    .blank(b0), .err_invalid(ei0), .err_overflow(eo0), .err_clr(err_clr)
  );

  seg7_reader #(.STABLE_CYCLES(4), .REPORT_REPEATS(1)) dut_rep (
    .clk(clk), .rst(rst), .en(en), .segments_in(seg),
    .digit_out(d1), .digit_valid(v1), .digit_ready(digit_ready),
    .blank(b1), .err_invalid(ei1), .err_overflow(eo1), .err_clr(err_clr)
  );

  always @(negedge clk) begin
    if (!rst && v0 && digit_ready) begin
      hs0   <= hs0 + 1;
      last0 <= int'(d0);
    end
    if (!rst && v1 && digit_ready) begin
      hs1   <= hs1 + 1;
      last1 <= int'(d1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [6:0] pat;
    int         n;
    int         dig;
    int         bl;
    int         inv;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  int base0, base1;

  initial begin
    tbl[0]  = '{7'b0111111, 1, 0, 0, 0};
    tbl[1]  = '{7'b0000110, 1, 1, 0, 0};
    tbl[2]  = '{7'b1011011, 1, 2, 0, 0};
    tbl[3]  = '{7'b1001111, 1, 3, 0, 0};
    tbl[4]  = '{7'b1100110, 1, 4, 0, 0};
    tbl[5]  = '{7'b1101101, 1, 5, 0, 0};
    tbl[6]  = '{7'b1111101, 1, 6, 0, 0};
    tbl[7]  = '{7'b0000111, 1, 7, 0, 0};
    tbl[8]  = '{7'b0000000, 0, 0, 1, 0};
    tbl[9]  = '{7'b0000111, 1, 7, 0, 0};
    tbl[10] = '{7'b1111111, 0, 0, 0, 1};
    tbl[11] = '{7'b0111110, 0, 0, 0, 1};
    tbl[12] = '{7'b0111111, 1, 0, 0, 0};

    // Reset state, then first-transaction latency
    rst = 1'b1; en = 1'b1; digit_ready = 1'b1; err_clr = 1'b0;
    seg = 7'b1011011;
    #12;
    check("reset digit_valid", int'(v0), 0);
    check("reset digit_out", int'(d0), 0);
    check("reset blank", int'(b0), 0);
    check("reset err_invalid", int'(ei0), 0);
    check("reset err_overflow", int'(eo0), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (k >= 5) check($sformatf("latency valid edge %0d", k), int'(v0), (k == 6) ? 1 : 0);
      if (k == 6) check("latency digit", int'(d0), 2);
    end
    check("latency err_invalid", int'(ei0), 0);
    check("latency err_overflow", int'(eo0), 0);

    // Decode table
    for (int i = 0; i < 13; i++) begin
      pulse_clr();
      base0 = hs0;
      seg = tbl[i].pat;
      step(9);
      check($sformatf("vec %0d count", i), hs0 - base0, tbl[i].n);
      if (tbl[i].n == 1) check($sformatf("vec %0d digit", i), last0, tbl[i].dig);
      check($sformatf("vec %0d blank", i), int'(b0), tbl[i].bl);
      check($sformatf("vec %0d err_invalid", i), int'(ei0), tbl[i].inv);
    end

    // Overflow: held digit survives a dropped one
    pulse_clr();
    digit_ready = 1'b0;
    seg = 7'b1111101;
    step(9);
    check("ovf held valid", int'(v0), 1);
    check("ovf held digit", int'(d0), 6);
    seg = 7'b0000110;
    step(10);
    check("ovf flag", int'(eo0), 1);
    check("ovf digit unchanged", int'(d0), 6);
    check("ovf valid kept", int'(v0), 1);
    base0 = hs0;
    digit_ready = 1'b1;
    step(4);
    check("ovf drain count", hs0 - base0, 1);
    check("ovf drain digit", last0, 6);
    check("ovf drain valid", int'(v0), 0);
    pulse_clr();
    check("ovf cleared", int'(eo0), 0);

    // Repeat filter: short glitch, then a 5-cycle invalid excursion
    seg = 7'b1001111;
    step(9);
    base0 = hs0; base1 = hs1;
    seg = 7'b1001110;
    step(1);
    seg = 7'b1001111;
    step(10);
    check("glitch suppressed count", hs0 - base0, 0);
    check("glitch reported count", hs1 - base1, 1);
    check("glitch no invalid", int'(ei0), 0);
    check("glitch no invalid rep", int'(ei1), 0);
    seg = 7'b1001110;
    step(5);
    seg = 7'b1001111;
    step(10);
    check("excursion invalid", int'(ei0), 1);
    check("excursion invalid rep", int'(ei1), 1);
    check("excursion count", hs0 - base0, 1);
    check("excursion count rep", hs1 - base1, 2);
    check("excursion digit", last0, 3);
    check("excursion digit rep", last1, 3);

    // Blank between equal digits
    pulse_clr();
    base0 = hs0;
    seg = 7'b0000000;
    step(9);
    check("blank 1 level", int'(b0), 1);
    seg = 7'b0000111;
    step(9);
    check("blank 1 cleared", int'(b0), 0);
    seg = 7'b0000000;
    step(9);
    check("blank 2 level", int'(b0), 1);
    seg = 7'b0000111;
    step(9);
    check("blank 2 cleared", int'(b0), 0);
    check("blank sevens count", hs0 - base0, 2);
    check("blank sevens digit", last0, 7);

    // err_clr in the same cycle as an invalid event
    seg = 7'b1111111;
    step(9);
    check("errclr first invalid", int'(ei0), 1);
    seg = 7'b0000000;
    step(9);
    seg = 7'b1111111;
    step(6);
    check("errclr pre-event blank", int'(b0), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("errclr event landed", int'(b0), 0);
    check("errclr set wins", int'(ei0), 1);
    pulse_clr();
    check("errclr alone", int'(ei0), 0);

    // Asynchronous reset mid-handshake
    digit_ready = 1'b0;
    seg = 7'b1101101;
    step(9);
    check("pre-rst valid", int'(v0), 1);
    check("pre-rst digit", int'(d0), 5);
    #3;
    rst = 1'b1;
    #1;
    check("rst valid", int'(v0), 0);
    check("rst digit", int'(d0), 0);
    check("rst blank", int'(b0), 0);
    check("rst err_invalid", int'(ei0), 0);
    check("rst err_overflow", int'(eo0), 0);
    seg = 7'b1100110;
    digit_ready = 1'b1;
    en = 1'b1;
    #2;
    rst = 1'b0;

    // en dropped for two cycles mid-count
    base0 = hs0;
    step(4);
    en = 1'b0;
    step(2);
    en = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      step(1);
      check($sformatf("en-drop valid edge %0d", k), int'(v0), (k == 9) ? 1 : 0);
    end
    check("en-drop digit", int'(d0), 4);
    step(2);
    check("en-drop count", hs0 - base0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
